// File: rtl/input_buffer_pkg.sv
// Shared types for the receive ping-pong buffer: sample bus, controller pop
// report and the default bank depth.
package input_buffer_pkg;

    localparam int DATA_WIDTH = 32;
    localparam int FRAME_LEN  = 16;

    typedef logic [DATA_WIDTH-1:0] DATA_SAMPLE;

    typedef struct packed {
        logic       valid;
        DATA_SAMPLE data;
    } DATA_BUS;

    typedef struct packed {
        logic valid;
    } RX_TO_CONT;

endpackage

// File: rtl/input_buffer_if.sv
// Handshake bundle between upstream source, input_buffer and the FIR IP core.
// master = upstream/IP side, slave = the buffer itself.
interface input_buffer_if;
    import input_buffer_pkg::*;

    DATA_BUS   data_in;
    logic      tlast_in;
    logic      ready_out;
    DATA_BUS   data_out;
    logic      ip_ready;
    RX_TO_CONT rx_to_cont;
    logic      last_out;

    modport master (
        output data_in, tlast_in, ip_ready,
        input  ready_out, data_out, rx_to_cont, last_out
    );

    modport slave (
        input  data_in, tlast_in, ip_ready,
        output ready_out, data_out, rx_to_cont, last_out
    );

endinterface

// File: rtl/input_buffer_ram.sv
// Single-port bank RAM with synchronous read; a write wins the port when both
// strobes are raised, which the ping-pong pointers never do to one bank.
module ram #(
    parameter int DATA_WIDTH = 32,
    parameter int MEM_SIZE   = 16
) (
    input  logic                          clk,
    input  logic                          i_we,
    input  logic                          i_re,
    input  logic [$clog2(MEM_SIZE)-1:0]   i_addr,
    input  logic [DATA_WIDTH-1:0]         i_wdata,
    output logic [DATA_WIDTH-1:0]         o_rdata
);

    logic [DATA_WIDTH-1:0] r_mem [MEM_SIZE];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end else if (i_re) begin
            o_rdata <= r_mem[i_addr];
        end
    end

endmodule

// File: rtl/input_buffer.sv
// Ping-pong receive buffer: fills two banks from the upstream stream and drains
// closed frames to the FIR IP in arrival order, two cycles after each pop.
module input_buffer #(
    parameter int DATA_WIDTH = input_buffer_pkg::DATA_WIDTH,
    parameter int FRAME_LEN  = input_buffer_pkg::FRAME_LEN
) (
    input  logic           clk,
    input  logic           rst_n,
    input_buffer_if.slave  bus
);
    import input_buffer_pkg::*;

    localparam int CNT_W = $clog2(FRAME_LEN);

    logic [1:0]                  r_full;
    logic [1:0]                  r_lst;
    logic [1:0][CNT_W:0]         r_len;
    logic                        r_wrSel;
    logic                        r_rdSel;
    logic [CNT_W-1:0]            r_wrCnt;
    logic [CNT_W-1:0]            r_rdCnt;

    logic                        r_p1Valid;
    logic                        r_p1Bank;
    logic                        r_p1Last;
    logic                        r_outValid;
    logic [DATA_WIDTH-1:0]       r_outData;
    logic                        r_outLast;

    logic                        w_accept;
    logic                        w_close;
    logic                        w_pop;
    logic                        w_popLast;
    logic [1:0]                  w_we;
    logic [1:0]                  w_re;
    logic [1:0][CNT_W-1:0]       w_addr;
    logic [1:0][DATA_WIDTH-1:0]  w_rdata;

    assign bus.ready_out = !r_full[r_wrSel];
    assign w_accept      = bus.data_in.valid && bus.ready_out;
    assign w_close       = w_accept && ((r_wrCnt == CNT_W'(FRAME_LEN - 1)) || bus.tlast_in);
    assign w_pop         = bus.ip_ready && r_full[r_rdSel];
    assign w_popLast     = w_pop && ({1'b0, r_rdCnt} == (r_len[r_rdSel] - 1'b1));

    // A bank is either filling (!full) or draining (full), so its port is never contended.
    always_comb begin
        w_we          = '0;
        w_re          = '0;
        w_we[r_wrSel] = w_accept;
        w_re[r_rdSel] = w_pop;
        w_addr[0]     = w_we[0] ? r_wrCnt : r_rdCnt;
        w_addr[1]     = w_we[1] ? r_wrCnt : r_rdCnt;
    end

    ram #(.DATA_WIDTH(DATA_WIDTH), .MEM_SIZE(FRAME_LEN)) ib0 (
        .clk     (clk),
        .i_we    (w_we[0]),
        .i_re    (w_re[0]),
        .i_addr  (w_addr[0]),
        .i_wdata (bus.data_in.data),
        .o_rdata (w_rdata[0])
    );

    ram #(.DATA_WIDTH(DATA_WIDTH), .MEM_SIZE(FRAME_LEN)) ib1 (
        .clk     (clk),
        .i_we    (w_we[1]),
        .i_re    (w_re[1]),
        .i_addr  (w_addr[1]),
        .i_wdata (bus.data_in.data),
        .o_rdata (w_rdata[1])
    );

    // Close and drain-complete always target different banks, so both updates land.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_full  <= '0;
            r_lst   <= '0;
            r_len   <= '0;
            r_wrSel <= 1'b0;
            r_rdSel <= 1'b0;
            r_wrCnt <= '0;
            r_rdCnt <= '0;
        end else begin
            if (w_accept) begin
                if (w_close) begin
                    r_full[r_wrSel] <= 1'b1;
                    r_len[r_wrSel]  <= {1'b0, r_wrCnt} + 1'b1;
                    r_lst[r_wrSel]  <= bus.tlast_in;
                    r_wrSel         <= ~r_wrSel;
                    r_wrCnt         <= '0;
                end else begin
                    r_wrCnt <= r_wrCnt + 1'b1;
                end
            end
            if (w_pop) begin
                if (w_popLast) begin
                    r_full[r_rdSel] <= 1'b0;
                    r_rdSel         <= ~r_rdSel;
                    r_rdCnt         <= '0;
                end else begin
                    r_rdCnt <= r_rdCnt + 1'b1;
                end
            end
        end
    end

    // Stage 1 tracks the RAM read in flight; stage 2 registers the beat for the IP.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_p1Valid  <= 1'b0;
            r_p1Bank   <= 1'b0;
            r_p1Last   <= 1'b0;
            r_outValid <= 1'b0;
            r_outData  <= '0;
            r_outLast  <= 1'b0;
        end else begin
            r_p1Valid  <= w_pop;
            r_p1Bank   <= r_rdSel;
            r_p1Last   <= w_popLast && r_lst[r_rdSel];
            r_outValid <= r_p1Valid;
            r_outData  <= r_p1Valid ? w_rdata[r_p1Bank] : '0;
            r_outLast  <= r_p1Valid && r_p1Last;
        end
    end

    assign bus.rx_to_cont.valid = r_p1Valid;
    assign bus.data_out         = {r_outValid, r_outData};
    assign bus.last_out         = r_outLast;

endmodule

// File: tb/tb_input_buffer.sv
// Scoreboard bench for input_buffer: accepted beats are queued with their
// expected last flag and matched against every data_out beat.
module tb_input_buffer;
    import input_buffer_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    input_buffer_if ibIf();

    input_buffer dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ibIf)
    );

    logic [32:0] expQ [$];
    int  nCompared    = 0;
    int  nMismatched  = 0;
    int  cyc          = 0;
    int  outCount     = 0;
    int  rxCount      = 0;
    int  lastCount    = 0;
    int  lastAcceptCyc = 0;
    int  firstOutCyc  = -1;
    bit  toggleReady  = 1'b0;

    always @(posedge clk) cyc++;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        nCompared++;
        if (observed !== expected) begin
            nMismatched++;
            $display("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Output monitor: every beat must match the head of the expected queue.
    always @(negedge clk) begin
        logic [32:0] e;
        if (rst_n) begin
            if (ibIf.rx_to_cont.valid) rxCount++;
            if (ibIf.data_out.valid) begin
                outCount++;
                if (ibIf.last_out) lastCount++;
                if (firstOutCyc < 0) firstOutCyc = cyc;
                if (expQ.size() == 0) begin
                    checkOutput("spuriousOut", 64'(ibIf.data_out.valid), 64'd0);
                end else begin
                    e = expQ.pop_front();
                    checkOutput("outData", 64'(ibIf.data_out.data), 64'(e[31:0]));
                    checkOutput("outLast", 64'(ibIf.last_out), 64'(e[32]));
                end
            end else begin
                checkOutput("idleZero", 64'({ibIf.last_out, ibIf.data_out.data}), 64'd0);
            end
        end
    end

    task automatic applyStimulus(input logic [31:0] d, input logic t);
        int tries = 0;
        bit acc   = 1'b0;
        while (!acc && tries < 200) begin
            @(negedge clk);
            ibIf.data_in  = {1'b1, d};
            ibIf.tlast_in = t;
            if (toggleReady) ibIf.ip_ready = ~ibIf.ip_ready;
            #4;
            if (ibIf.ready_out) begin
                acc = 1'b1;
                expQ.push_back({t, d});
                lastAcceptCyc = cyc + 1;
            end
            tries++;
        end
        if (!acc) checkOutput("acceptTimeout", 64'(ibIf.ready_out), 64'd1);
    endtask

    task automatic endBurst();
        @(negedge clk);
        ibIf.data_in  = '0;
        ibIf.tlast_in = 1'b0;
    endtask

    task automatic waitDrain(input string tag);
        int n = 0;
        while (expQ.size() != 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        repeat (6) @(negedge clk);
        #1;
        checkOutput({tag, "_drained"}, 64'(expQ.size()), 64'd0);
    endtask

    initial begin
        int o0, r0, l0, d;
        ibIf.data_in  = '0;
        ibIf.tlast_in = 1'b0;
        ibIf.ip_ready = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        #1;
        checkOutput("rstDataOut", 64'(ibIf.data_out), 64'd0);
        checkOutput("rstRx", 64'(ibIf.rx_to_cont.valid), 64'd0);
        checkOutput("rstLast", 64'(ibIf.last_out), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checkOutput("rstReady", 64'(ibIf.ready_out), 64'd1);

        // Short tlast frame, then a follow-up frame in the other bank
        ibIf.ip_ready = 1'b1;
        o0 = outCount; l0 = lastCount;
        for (int i = 0; i < 5; i++) applyStimulus(32'hA0 + i, i == 4);
        endBurst();
        waitDrain("short");
        checkOutput("shortCount", 64'(outCount - o0), 64'd5);
        checkOutput("shortLastCount", 64'(lastCount - l0), 64'd1);
        o0 = outCount;
        for (int i = 0; i < 3; i++) applyStimulus(32'hB0 + i, i == 2);
        endBurst();
        waitDrain("follow");
        checkOutput("followCount", 64'(outCount - o0), 64'd3);

        // Full frame without tlast, first-word latency
        o0 = outCount; r0 = rxCount; l0 = lastCount; firstOutCyc = -1;
        for (int i = 1; i <= 16; i++) applyStimulus(32'(i), 1'b0);
        endBurst();
        waitDrain("full");
        checkOutput("fullCount", 64'(outCount - o0), 64'd16);
        checkOutput("fullRxCount", 64'(rxCount - r0), 64'd16);
        checkOutput("fullLastCount", 64'(lastCount - l0), 64'd0);
        checkOutput("fullLatency", 64'(firstOutCyc - lastAcceptCyc), 64'd2);

        // tlast on the 16th word, then a length-1 frame
        o0 = outCount; l0 = lastCount;
        for (int i = 0; i < 16; i++) applyStimulus(32'h100 + i, i == 15);
        endBurst();
        waitDrain("boundary");
        checkOutput("boundaryCount", 64'(outCount - o0), 64'd16);
        checkOutput("boundaryLastCount", 64'(lastCount - l0), 64'd1);
        o0 = outCount; l0 = lastCount;
        applyStimulus(32'h55, 1'b1);
        endBurst();
        waitDrain("single");
        checkOutput("singleCount", 64'(outCount - o0), 64'd1);
        checkOutput("singleLastCount", 64'(lastCount - l0), 64'd1);

        // Both banks full: 33rd beat held until the first bank drains
        @(negedge clk);
        ibIf.ip_ready = 1'b0;
        o0 = outCount;
        for (int i = 1; i <= 32; i++) applyStimulus(32'(i), 1'b0);
        @(negedge clk);
        ibIf.data_in  = {1'b1, 32'd33};
        ibIf.tlast_in = 1'b1;
        #1;
        checkOutput("bpReadyLow", 64'(ibIf.ready_out), 64'd0);
        repeat (3) @(negedge clk);
        ibIf.ip_ready = 1'b1;
        r0 = rxCount;
        d  = 0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            #1;
            d = rxCount - r0;
            if (d == 15) checkOutput("bpReadyHeld", 64'(ibIf.ready_out), 64'd0);
            if (d >= 16) break;
        end
        checkOutput("bpPopCount", 64'(d), 64'd16);
        checkOutput("bpReadyRise", 64'(ibIf.ready_out), 64'd1);
        expQ.push_back({1'b1, 32'd33});
        endBurst();
        waitDrain("backpressure");
        checkOutput("bpCount", 64'(outCount - o0), 64'd33);

        // Stall mid-drain: ip_ready toggles on every driven cycle
        o0 = outCount; r0 = rxCount;
        toggleReady = 1'b1;
        for (int i = 0; i < 40; i++) applyStimulus(32'h300 + i, i == 39);
        toggleReady = 1'b0;
        endBurst();
        ibIf.ip_ready = 1'b1;
        waitDrain("stall");
        checkOutput("stallCount", 64'(outCount - o0), 64'd40);
        checkOutput("stallRxVsOut", 64'(rxCount - r0), 64'(outCount - o0));

        // Async reset mid-frame while a frame is draining
        for (int i = 0; i < 16; i++) applyStimulus(32'h400 + i, 1'b0);
        for (int i = 0; i < 4; i++) applyStimulus(32'h500 + i, 1'b0);
        endBurst();
        #2;
        checkOutput("preRstValid", 64'(ibIf.data_out.valid), 64'd1);
        rst_n = 1'b0;
        #1;
        checkOutput("asyncRstData", 64'(ibIf.data_out), 64'd0);
        checkOutput("asyncRstRx", 64'(ibIf.rx_to_cont.valid), 64'd0);
        checkOutput("asyncRstLast", 64'(ibIf.last_out), 64'd0);
        expQ.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        checkOutput("postRstReady", 64'(ibIf.ready_out), 64'd1);
        o0 = outCount; l0 = lastCount;
        for (int i = 0; i < 16; i++) applyStimulus(32'h600 + i, 1'b0);
        endBurst();
        waitDrain("postRst");
        checkOutput("postRstCount", 64'(outCount - o0), 64'd16);
        checkOutput("postRstLastCount", 64'(lastCount - l0), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
